// File: rtl/switch_matrix_cfg_loader_if.sv
// ---------------------------------------------------------------------------
// switch_matrix_cfg_loader_if
//   Bundles the serial configuration stream and the committed route bus of the
//   switch-matrix configuration loader.
//   master : configuration source (drives start/abort/valid/bit, observes status)
//   slave  : the loader itself
//   Signals:
//     cfg_start, cfg_abort       frame control from the source
//     cfg_valid, cfg_bit         serial data beat, qualified by cfg_ready
//     cfg_ready                  loader accepts a beat this cycle
//     cfg_bus                    committed flat route-select bus
//     cfg_busy, cfg_done, cfg_err, err_status, cfg_gen   loader status
// ---------------------------------------------------------------------------
interface switch_matrix_cfg_loader_if #(
  parameter int BUS_W = 108
) ();
  logic             cfg_start;
  logic             cfg_abort;
  logic             cfg_valid;
  logic             cfg_bit;
  logic             cfg_ready;
  logic [BUS_W-1:0] cfg_bus;
  logic             cfg_busy;
  logic             cfg_done;
  logic             cfg_err;
  logic [1:0]       err_status;
  logic [3:0]       cfg_gen;

  modport master (
    output cfg_start, cfg_abort, cfg_valid, cfg_bit,
    input  cfg_ready, cfg_bus, cfg_busy, cfg_done, cfg_err, err_status, cfg_gen
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_valid, cfg_bit,
    output cfg_ready, cfg_bus, cfg_busy, cfg_done, cfg_err, err_status, cfg_gen
  );
endinterface

// File: rtl/switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// switch_matrix_cfg_loader
//   Hunts for a sync byte in a serial MSB-first stream, assembles 18 six-bit
//   route entries into a shadow store, verifies an XOR checksum and the side
//   codes, and only then commits the whole shadow store to cfg_bus at once.
//   A partial, aborted or corrupt frame never reaches cfg_bus.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     cfg    loader side of switch_matrix_cfg_loader_if (stream in, bus/status out)
// ---------------------------------------------------------------------------
module switch_matrix_cfg_loader #(
  parameter int         N_TB    = 5,
  parameter int         N_LR    = 4,
  parameter int         ENTRY_W = 6,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input logic                     clk,
  input logic                     rst_n,
  switch_matrix_cfg_loader_if.slave cfg
);
  localparam int N_ENT = 2 * (N_TB + N_LR);
  localparam int BUS_W = N_ENT * ENTRY_W;
  localparam int CNT_W = $clog2(BUS_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BUS_W - 1);
  localparam logic [2:0]       LAST_SUB = 3'(ENTRY_W - 1);

  typedef enum logic [2:0] {IDLE, HUNT, LOAD, CHECK, EVAL} state_t;

  // Side codes 5..7 do not name a matrix side.
  function automatic logic bad_side(input logic [2:0] side);
    bad_side = (side > 3'd4);
  endfunction

  state_t             state_r, state_s;
  logic [7:0]         win_r;
  logic [CNT_W-1:0]   bit_cnt_r;
  logic [2:0]         sub_cnt_r;
  logic [4:0]         ent_cnt_r;
  logic [ENTRY_W-2:0] ent_sr_r;
  logic [BUS_W-1:0]   shadow_r;
  logic [ENTRY_W-1:0] acc_r;
  logic               code_flag_r;
  logic [ENTRY_W-1:0] csum_r;
  logic [2:0]         csum_cnt_r;
  logic [BUS_W-1:0]   bus_r;
  logic [3:0]         gen_r;
  logic [1:0]         err_status_r;
  logic               done_r, err_r, ready_r, busy_r;

  logic               beat_s, clr_s, clr_err_s, commit_s, reject_s, pass_s;
  logic [ENTRY_W-1:0] ent_s;

  assign beat_s = cfg.cfg_valid & ready_r;
  // Completed entry: five bits already shifted in plus the current beat.
  assign ent_s  = {ent_sr_r, cfg.cfg_bit};
  assign pass_s = (csum_r == acc_r) && !code_flag_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic and one-cycle control strobes; abort overrides everything.
  always_comb begin
    state_s   = state_r;
    clr_s     = 1'b0;
    clr_err_s = 1'b0;
    commit_s  = 1'b0;
    reject_s  = 1'b0;
    if (cfg.cfg_abort) begin
      state_s = IDLE;
      clr_s   = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (cfg.cfg_start) begin
            state_s   = HUNT;
            clr_s     = 1'b1;
            clr_err_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        HUNT: begin
          if (beat_s && ({win_r[6:0], cfg.cfg_bit} == SYNC)) begin
            state_s = LOAD;
          end else begin
            state_s = HUNT;
          end
        end
        LOAD: begin
          if (beat_s && (bit_cnt_r == LAST_BIT)) begin
            state_s = CHECK;
          end else begin
            state_s = LOAD;
          end
        end
        CHECK: begin
          if (beat_s && (csum_cnt_r == LAST_SUB)) begin
            state_s = EVAL;
          end else begin
            state_s = CHECK;
          end
        end
        EVAL: begin
          state_s = IDLE;
          if (pass_s) begin
            commit_s = 1'b1;
          end else begin
            reject_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Datapath: sync window, entry assembly, checksum capture, commit and status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r        <= 8'd0;
      bit_cnt_r    <= '0;
      sub_cnt_r    <= 3'd0;
      ent_cnt_r    <= 5'd0;
      ent_sr_r     <= '0;
      shadow_r     <= '0;
      acc_r        <= '0;
      code_flag_r  <= 1'b0;
      csum_r       <= '0;
      csum_cnt_r   <= 3'd0;
      bus_r        <= '0;
      gen_r        <= 4'd0;
      err_status_r <= 2'b00;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      done_r  <= commit_s;
      err_r   <= reject_s;
      ready_r <= (state_s == HUNT) || (state_s == LOAD) || (state_s == CHECK);
      busy_r  <= (state_s != IDLE);

      if (clr_s) begin
        win_r       <= 8'd0;
        bit_cnt_r   <= '0;
        sub_cnt_r   <= 3'd0;
        ent_cnt_r   <= 5'd0;
        ent_sr_r    <= '0;
        acc_r       <= '0;
        code_flag_r <= 1'b0;
        csum_r      <= '0;
        csum_cnt_r  <= 3'd0;
      end else if (beat_s) begin
        case (state_r)
          HUNT: begin
            win_r <= {win_r[6:0], cfg.cfg_bit};
          end
          LOAD: begin
            bit_cnt_r <= bit_cnt_r + 1'b1;
            ent_sr_r  <= ent_s[ENTRY_W-2:0];
            if (sub_cnt_r == LAST_SUB) begin
              shadow_r[ent_cnt_r * ENTRY_W +: ENTRY_W] <= ent_s;
              acc_r       <= acc_r ^ ent_s;
              code_flag_r <= code_flag_r | bad_side(ent_s[2:0]);
              sub_cnt_r   <= 3'd0;
              ent_cnt_r   <= ent_cnt_r + 1'b1;
            end else begin
              sub_cnt_r <= sub_cnt_r + 1'b1;
            end
          end
          CHECK: begin
            csum_r     <= {csum_r[ENTRY_W-2:0], cfg.cfg_bit};
            csum_cnt_r <= csum_cnt_r + 1'b1;
          end
          default: begin
          end
        endcase
      end else begin
      end

      if (commit_s) begin
        bus_r <= shadow_r;
        gen_r <= gen_r + 4'd1;
      end else begin
      end

      if (clr_err_s) begin
        err_status_r <= 2'b00;
      end else if (reject_s) begin
        err_status_r <= err_status_r | {code_flag_r, (csum_r != acc_r)};
      end else begin
      end
    end
  end

  assign cfg.cfg_ready  = ready_r;
  assign cfg.cfg_bus    = bus_r;
  assign cfg.cfg_busy   = busy_r;
  assign cfg.cfg_done   = done_r;
  assign cfg.cfg_err    = err_r;
  assign cfg.err_status = err_status_r;
  assign cfg.cfg_gen    = gen_r;
endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_switch_matrix_cfg_loader
//   Scoreboard bench: each complete frame pushes its expected outcome (pass or
//   fail, bus, err_status, generation) when it is driven; a negedge monitor pops
//   and compares whenever cfg_done or cfg_err pulses.
// ---------------------------------------------------------------------------
module tb_switch_matrix_cfg_loader;
  typedef struct {
    logic         pass;
    logic [107:0] bus;
    logic [1:0]   est;
    logic [3:0]   gen;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   gap_en = 1'b0;

  exp_t         sb[$];
  exp_t         mon_e;
  logic [5:0]   ents[18];
  logic [107:0] exp_bus = '0;
  logic [3:0]   exp_gen = 4'd0;

  switch_matrix_cfg_loader_if ifc ();

  switch_matrix_cfg_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg   (ifc.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [107:0] got, input logic [107:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pop and compare on every completion pulse.
  always @(negedge clk) begin
    if (rst_n && (ifc.cfg_done || ifc.cfg_err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 108'({ifc.cfg_done, ifc.cfg_err}), 108'(0));
      end else begin
        mon_e = sb.pop_front();
        check("done",       108'(ifc.cfg_done),   108'(mon_e.pass));
        check("err",        108'(ifc.cfg_err),    108'(!mon_e.pass));
        check("bus",        ifc.cfg_bus,          mon_e.bus);
        check("gen",        108'(ifc.cfg_gen),    108'(mon_e.gen));
        check("err_status", 108'(ifc.err_status), 108'(mon_e.est));
      end
    end
  end

  task automatic send_bit(input logic b);
    int g;
    int tries;
    g = gap_en ? int'($urandom_range(0, 3)) : 0;
    repeat (g) begin
      @(negedge clk);
      ifc.cfg_valid = 1'b0;
    end
    @(negedge clk);
    ifc.cfg_valid = 1'b1;
    ifc.cfg_bit   = b;
    tries = 0;
    while (!ifc.cfg_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    if (!ifc.cfg_ready) check("ready_timeout", 108'(ifc.cfg_ready), 108'(1));
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clk);
    ifc.cfg_start = 1'b1;
    @(negedge clk);
    ifc.cfg_start = 1'b0;
    check("busy_after_start",  108'(ifc.cfg_busy),  108'(1));
    check("ready_after_start", 108'(ifc.cfg_ready), 108'(1));
  endtask

  task automatic send_entry_bits(input int nbits);
    for (int j = 0; j < nbits; j++) send_bit(ents[j / 6][5 - (j % 6)]);
  endtask

  // Drive one full frame from ents[] with the given checksum and score it.
  task automatic send_frame(input logic [5:0] csum);
    exp_t         e;
    logic [107:0] bus;
    logic [5:0]   acc;
    logic         flag;
    bus  = '0;
    acc  = 6'd0;
    flag = 1'b0;
    for (int k = 0; k < 18; k++) begin
      bus[k*6 +: 6] = ents[k];
      acc  = acc ^ ents[k];
      flag = flag | (ents[k][2:0] > 3'd4);
    end
    e.pass = (csum == acc) && !flag;
    if (e.pass) begin
      exp_bus = bus;
      exp_gen = exp_gen + 4'd1;
    end
    e.bus = exp_bus;
    e.gen = exp_gen;
    e.est = e.pass ? 2'b00 : {flag, (csum != acc)};
    sb.push_back(e);
    do_start();
    send_bits(8'hA5, 8);
    send_entry_bits(108);
    send_bits({2'b00, csum}, 6);
    idle_bus();
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      check("pulse_timeout", 108'(sb.size()), 108'(0));
      sb.delete();
    end
  endtask

  task automatic clear_ents();
    for (int k = 0; k < 18; k++) ents[k] = 6'd0;
  endtask

  task automatic random_ents(output logic [5:0] csum);
    csum = 6'd0;
    for (int k = 0; k < 18; k++) begin
      ents[k] = {3'($urandom_range(0, 7)), 3'($urandom_range(0, 4))};
      csum = csum ^ ents[k];
    end
  endtask

  initial begin
    logic [5:0] cs;
    ifc.cfg_start = 1'b0;
    ifc.cfg_abort = 1'b0;
    ifc.cfg_valid = 1'b0;
    ifc.cfg_bit   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    repeat (10) @(negedge clk);
    check("rst_bus",   ifc.cfg_bus,          108'(0));
    check("rst_ready", 108'(ifc.cfg_ready),  108'(0));
    check("rst_busy",  108'(ifc.cfg_busy),   108'(0));
    check("rst_gen",   108'(ifc.cfg_gen),    108'(0));
    check("rst_done",  108'(ifc.cfg_done),   108'(0));
    check("rst_err",   108'(ifc.cfg_err),    108'(0));
    check("rst_est",   108'(ifc.err_status), 108'(0));

    // Good frame: entry0 = 6'o12.
    clear_ents();
    ents[0] = 6'o12;
    send_frame(6'o12);

    // Same frame with a wrong checksum.
    send_frame(6'o00);

    // Illegal side code with a correct checksum.
    clear_ents();
    ents[7] = 6'o15;
    send_frame(6'o15);

    // Prefix 1,1,0,1 before sync, random valid gaps.
    clear_ents();
    ents[0] = 6'o12;
    gap_en  = 1'b1;
    begin
      exp_t         e;
      logic [107:0] b;
      b = '0;
      b[5:0]  = 6'o12;
      exp_bus = b;
      exp_gen = exp_gen + 4'd1;
      e.pass = 1'b1;
      e.bus  = exp_bus;
      e.gen  = exp_gen;
      e.est  = 2'b00;
      sb.push_back(e);
      do_start();
      send_bits(8'h0D, 4);
      send_bits(8'hA5, 8);
      send_entry_bits(108);
      send_bits(8'o12, 6);
      idle_bus();
      for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
      if (sb.size() != 0) begin
        check("pulse_timeout", 108'(sb.size()), 108'(0));
        sb.delete();
      end
    end
    gap_en = 1'b0;

    // Abort in the middle of LOAD, then a full random frame.
    random_ents(cs);
    do_start();
    send_bits(8'hA5, 8);
    send_entry_bits(50);
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
    ifc.cfg_abort = 1'b1;
    @(negedge clk);
    ifc.cfg_abort = 1'b0;
    check("abort_busy",  108'(ifc.cfg_busy),  108'(0));
    check("abort_ready", 108'(ifc.cfg_ready), 108'(0));
    repeat (4) @(negedge clk);
    check("abort_bus", ifc.cfg_bus,        exp_bus);
    check("abort_gen", 108'(ifc.cfg_gen),  108'(exp_gen));
    send_frame(cs);

    // Abort together with start stays idle.
    @(negedge clk);
    ifc.cfg_start = 1'b1;
    ifc.cfg_abort = 1'b1;
    @(negedge clk);
    ifc.cfg_start = 1'b0;
    ifc.cfg_abort = 1'b0;
    check("abort_start_busy", 108'(ifc.cfg_busy), 108'(0));

    // Asynchronous reset in the middle of LOAD.
    random_ents(cs);
    do_start();
    send_bits(8'hA5, 8);
    send_entry_bits(30);
    @(negedge clk);
    ifc.cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    exp_bus = '0;
    exp_gen = 4'd0;
    check("mid_rst_bus",   ifc.cfg_bus,          108'(0));
    check("mid_rst_gen",   108'(ifc.cfg_gen),    108'(0));
    check("mid_rst_ready", 108'(ifc.cfg_ready),  108'(0));
    check("mid_rst_busy",  108'(ifc.cfg_busy),   108'(0));
    check("mid_rst_est",   108'(ifc.err_status), 108'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Frame after reset commits with generation 1.
    send_frame(cs);

    repeat (5) @(negedge clk);
    check("sb_empty", 108'(sb.size()), 108'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
